// File: rtl/hs_reg_slice_pkg.sv
// Shared definitions for the valid/ready register slice: per-stage state
// encoding and the output decode used by every skid stage.
package hs_reg_slice_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  function automatic logic stage_ready(input state_e st);
    return (st != ST_FULL);
  endfunction

  // The unused encoding 2'b11 decodes as not-valid so it can never emit data.
  function automatic logic stage_valid(input state_e st);
    return (st == ST_BUSY) || (st == ST_FULL);
  endfunction

endpackage

// File: rtl/hs_reg_slice_1s.sv
// One skid stage: registers valid/data forward and ready backward, holding
// up to two words (main + skid) so full throughput survives the ready flop.
module hs_reg_slice_1s
  import hs_reg_slice_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  state_e           state_r;
  state_e           state_nx_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nx_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nx_s;
  logic             s_ready_r;
  logic             m_valid_r;
  logic             in_s;
  logic             out_s;

  assign in_s  = s_valid && s_ready_r;
  assign out_s = m_valid_r && m_ready;

  // Next-state and datapath selection for the main/skid registers.
  always_comb begin
    state_nx_s = state_r;
    main_nx_s  = main_r;
    skid_nx_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_s) begin
          main_nx_s  = s_data;
          state_nx_s = ST_BUSY;
        end else begin
          state_nx_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (in_s && out_s) begin
          main_nx_s  = s_data;
          state_nx_s = ST_BUSY;
        end else if (in_s) begin
          skid_nx_s  = s_data;
          state_nx_s = ST_FULL;
        end else if (out_s) begin
          state_nx_s = ST_EMPTY;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        if (out_s) begin
          main_nx_s  = skid_r;
          state_nx_s = ST_BUSY;
        end else begin
          state_nx_s = ST_FULL;
        end
      end
      default: begin
        state_nx_s = ST_EMPTY;
      end
    endcase
  end

  // State and payload registers; the handshake outputs are decoded from the
  // next state so they come straight from flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_EMPTY;
      main_r    <= {WIDTH{1'b0}};
      skid_r    <= {WIDTH{1'b0}};
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      main_r    <= main_nx_s;
      skid_r    <= skid_nx_s;
      s_ready_r <= stage_ready(state_nx_s);
      m_valid_r <= stage_valid(state_nx_s);
    end
  end

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_data  = main_r;

endmodule

// File: rtl/hs_reg_slice.sv
// Valid/ready register slice: STAGE skid stages in series, or plain wires
// when STAGE is zero.
module hs_reg_slice
  import hs_reg_slice_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  generate
    if (STAGE == 0) begin : g_pass
      logic unused_s;
      assign unused_s = clk_i ^ rst_ni;
      assign s_ready  = m_ready;
      assign m_valid  = s_valid;
      assign m_data   = s_data;
    end else begin : g_chain
      logic             valid_s [STAGE+1];
      logic             ready_s [STAGE+1];
      logic [WIDTH-1:0] data_s  [STAGE+1];

      assign valid_s[0]     = s_valid;
      assign data_s[0]      = s_data;
      assign s_ready        = ready_s[0];
      assign ready_s[STAGE] = m_ready;
      assign m_valid        = valid_s[STAGE];
      assign m_data         = data_s[STAGE];

      for (genvar i = 0; i < STAGE; i++) begin : g_stage
        hs_reg_slice_1s #(
          .WIDTH(WIDTH)
        ) u_stage (
          .clk_i   (clk_i),
          .rst_ni  (rst_ni),
          .s_valid (valid_s[i]),
          .s_ready (ready_s[i]),
          .s_data  (data_s[i]),
          .m_valid (valid_s[i+1]),
          .m_ready (ready_s[i+1]),
          .m_data  (data_s[i+1])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_hs_reg_slice.sv
// Self-checking bench for hs_reg_slice: directed scenarios on STAGE=1/2/0 and
// a randomized scoreboard run on STAGE=3.
module tb_hs_reg_slice;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic        s_valid1 = 1'b0, s_ready1, m_valid1, m_ready1 = 1'b0;
  logic [31:0] s_data1 = 32'd0, m_data1;
  logic        s_valid2 = 1'b0, s_ready2, m_valid2, m_ready2 = 1'b0;
  logic [7:0]  s_data2 = 8'd0, m_data2;
  logic        s_valid3 = 1'b0, s_ready3, m_valid3, m_ready3 = 1'b0;
  logic [7:0]  s_data3 = 8'd0, m_data3;
  logic        s_valid0 = 1'b0, s_ready0, m_valid0, m_ready0 = 1'b0;
  logic [31:0] s_data0 = 32'd0, m_data0;

  hs_reg_slice #(.WIDTH(32), .STAGE(1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1));
  hs_reg_slice #(.WIDTH(8), .STAGE(2)) u_s2 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2));
  hs_reg_slice #(.WIDTH(8), .STAGE(3)) u_s3 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3));
  hs_reg_slice #(.WIDTH(32), .STAGE(0)) u_s0 (
    .clk_i(clk), .rst_ni(rst_n), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0));

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (s_ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b want 0", s_ready1); end
    n_checks++; if (m_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid1); end
    n_checks++; if (m_data1 !== 32'd0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data1); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (s_ready1 !== 1'b0) begin n_fail++; $display("FAIL release_s_ready_early got %b want 0", s_ready1); end
    @(posedge clk); #1;
    n_checks++; if (s_ready1 !== 1'b1) begin n_fail++; $display("FAIL release_s_ready got %b want 1", s_ready1); end
    n_checks++; if (m_valid1 !== 1'b0) begin n_fail++; $display("FAIL release_m_valid got %b want 0", m_valid1); end
  endtask

  task automatic test_streaming();
    int vcount = 0;
    m_ready1 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      s_valid1 = (c < 16);
      s_data1  = 32'(c + 1);
      @(posedge clk); #1;
      if (m_valid1) vcount++;
      n_checks++; if (m_valid1 !== (c < 16)) begin n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, m_valid1, (c < 16)); end
      if (c < 16) begin
        n_checks++; if (m_data1 !== 32'(c + 1)) begin n_fail++; $display("FAIL stream_data c=%0d got %0d want %0d", c, m_data1, c + 1); end
        n_checks++; if (s_ready1 !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready c=%0d got %b want 1", c, s_ready1); end
      end
    end
    n_checks++; if (vcount != 16) begin n_fail++; $display("FAIL stream_valid_cycles got %0d want 16", vcount); end
    s_valid1 = 1'b0;
  endtask

  task automatic test_backpressure();
    m_ready1 = 1'b0;
    s_valid1 = 1'b1; s_data1 = 32'hA0;
    @(posedge clk); #1;
    n_checks++; if (m_data1 !== 32'hA0 || m_valid1 !== 1'b1) begin n_fail++; $display("FAIL bp_first got v=%b d=%h want v=1 d=a0", m_valid1, m_data1); end
    n_checks++; if (s_ready1 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got %b want 1", s_ready1); end
    s_data1 = 32'hA1;
    @(posedge clk); #1;
    n_checks++; if (s_ready1 !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", s_ready1); end
    s_data1 = 32'hA2;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (s_ready1 !== 1'b0 || m_data1 !== 32'hA0 || m_valid1 !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold c=%0d got r=%b v=%b d=%h want r=0 v=1 d=a0", c, s_ready1, m_valid1, m_data1);
      end
    end
    m_ready1 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (m_data1 !== 32'hA1 || m_valid1 !== 1'b1) begin n_fail++; $display("FAIL bp_drain1 got v=%b d=%h want v=1 d=a1", m_valid1, m_data1); end
    n_checks++; if (s_ready1 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b want 1", s_ready1); end
    @(posedge clk); #1;
    s_valid1 = 1'b0;
    n_checks++; if (m_data1 !== 32'hA2 || m_valid1 !== 1'b1) begin n_fail++; $display("FAIL bp_drain2 got v=%b d=%h want v=1 d=a2", m_valid1, m_data1); end
    @(posedge clk); #1;
    n_checks++; if (m_valid1 !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", m_valid1); end
    m_ready1 = 1'b0;
  endtask

  task automatic test_random_stage3();
    logic [7:0] q[$];
    int         sent = 0, got = 0, cyc = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'd0;
    logic       sr, mv;
    logic [7:0] md;
    while (got < 1000 && cyc < 20000) begin
      s_valid3 = (sent < 1000) && ($urandom_range(0, 1) == 1);
      s_data3  = 8'($urandom);
      m_ready3 = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (hold_v) begin
        n_checks++; if (m_valid3 !== 1'b1 || m_data3 !== hold_d) begin
          n_fail++; $display("FAIL rnd_stable cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, m_valid3, m_data3, hold_d);
        end
      end
      sr = s_ready3; mv = m_valid3; md = m_data3;
      m_ready3 = ~m_ready3; s_valid3 = ~s_valid3; s_data3 = ~s_data3;
      #1;
      n_checks++; if (s_ready3 !== sr || m_valid3 !== mv || m_data3 !== md) begin
        n_fail++; $display("FAIL rnd_comb_path cyc=%0d got r=%b v=%b d=%h want r=%b v=%b d=%h", cyc, s_ready3, m_valid3, m_data3, sr, mv, md);
      end
      m_ready3 = ~m_ready3; s_valid3 = ~s_valid3; s_data3 = ~s_data3;
      if (s_valid3 && sr) begin q.push_back(s_data3); sent++; end
      hold_v = 1'b0;
      if (mv && m_ready3) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rnd_spurious cyc=%0d got d=%h want no word", cyc, md);
        end else begin
          n_checks++; if (md !== q[0]) begin n_fail++; $display("FAIL rnd_order cyc=%0d got %h want %h", cyc, md, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end else if (mv) begin
        hold_v = 1'b1; hold_d = md;
      end
      n_checks++; if (q.size() > 6) begin n_fail++; $display("FAIL rnd_occupancy cyc=%0d got %0d want <=6", cyc, q.size()); end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (got != 1000) begin n_fail++; $display("FAIL rnd_count got %0d want 1000", got); end
    s_valid3 = 1'b0; m_ready3 = 1'b0;
  endtask

  task automatic test_mid_reset();
    int sent = 0, cyc = 0, n = 0;
    m_ready2 = 1'b0;
    while (sent < 4 && cyc < 20) begin
      s_valid2 = 1'b1; s_data2 = 8'h11 + 8'(sent);
      @(negedge clk);
      if (s_ready2) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid2 = 1'b0;
    n_checks++; if (sent != 4) begin n_fail++; $display("FAIL mr_fill got %0d want 4", sent); end
    n_checks++; if (s_ready2 !== 1'b0 || m_valid2 !== 1'b1) begin n_fail++; $display("FAIL mr_full got r=%b v=%b want r=0 v=1", s_ready2, m_valid2); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid2 !== 1'b0 || s_ready2 !== 1'b0 || m_data2 !== 8'd0) begin
      n_fail++; $display("FAIL mr_async got v=%b r=%b d=%h want 0 0 00", m_valid2, s_ready2, m_data2);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (s_ready2 !== 1'b1 || m_valid2 !== 1'b0) begin n_fail++; $display("FAIL mr_release got r=%b v=%b want r=1 v=0", s_ready2, m_valid2); end
    m_ready2 = 1'b1; s_valid2 = 1'b1; s_data2 = 8'h55;
    @(posedge clk); #1;
    s_valid2 = 1'b0;
    @(negedge clk);
    while (!m_valid2 && n < 10) begin @(negedge clk); n++; end
    n_checks++; if (m_valid2 !== 1'b1 || m_data2 !== 8'h55) begin n_fail++; $display("FAIL mr_first_out got v=%b d=%h want v=1 d=55", m_valid2, m_data2); end
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL mr_latency got %0d want 1", n); end
    @(posedge clk); #1;
    n_checks++; if (m_valid2 !== 1'b0) begin n_fail++; $display("FAIL mr_drained got %b want 0", m_valid2); end
    m_ready2 = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      s_valid0 = ($urandom_range(0, 1) == 1);
      m_ready0 = ($urandom_range(0, 1) == 1);
      s_data0  = (i == 0) ? 32'hDEADBEEF : $urandom;
      #1;
      n_checks++; if (m_valid0 !== s_valid0 || m_data0 !== s_data0 || s_ready0 !== m_ready0) begin
        n_fail++; $display("FAIL pass i=%0d got v=%b d=%h r=%b want v=%b d=%h r=%b", i, m_valid0, m_data0, s_ready0, s_valid0, s_data0, m_ready0);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random_stage3();
    test_mid_reset();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
